// File: rtl/irq_aggregator.sv
// Eight-source interrupt aggregator with an Avalon-MM register file (PENDING, MASK,
// EDGE_SEL, ACTIVE, FORCE). Define IRQ_AGGREGATOR_SYNC_EN to add a two-flop input synchronizer.
module irq_aggregator (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic [7:0]  irq_in,
  output logic        irq_out
);

  typedef enum logic [2:0] {
    REG_PENDING  = 3'd0,
    REG_MASK     = 3'd1,
    REG_EDGE_SEL = 3'd2,
    REG_ACTIVE   = 3'd3,
    REG_FORCE    = 3'd4
  } reg_addr_e;

  logic [7:0]  s_d, s_q;
  logic [7:0]  p_q;
  logic [7:0]  pending_d, pending_q;
  logic [7:0]  mask_d, mask_q;
  logic [7:0]  edge_sel_d, edge_sel_q;
  logic [15:0] readdata_d, readdata_q;
  logic        irq_d, irq_q;

  logic        wr_en;
  logic [7:0]  wr_byte;
  logic [7:0]  rise;
  logic [7:0]  set_vec;
  logic [7:0]  clr_vec;
  logic [7:0]  edge_next;
  logic [7:0]  masked;
  logic        act_valid;
  logic [2:0]  act_idx;
  logic        unused_wdata_hi;

  assign wr_en           = chipselect & ~write_n;
  assign wr_byte         = writedata[7:0];
  assign unused_wdata_hi = ^writedata[15:8];

`ifdef IRQ_AGGREGATOR_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_d = sync2_q;
`else
  assign s_d = irq_in;
`endif

  // A rising edge is seen one stage after the sample so s and p never race.
  assign rise    = s_q & ~p_q;
  assign set_vec = rise | ((wr_en && address == REG_FORCE) ? wr_byte : 8'h00);
  assign clr_vec = (wr_en && address == REG_PENDING) ? wr_byte : 8'h00;

  // Set dominates clear when both hit the same edge-mode bit in one cycle.
  assign edge_next = (pending_q & ~clr_vec) | set_vec;
  assign masked    = pending_q & mask_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pending_d  = (edge_sel_q & edge_next) | (~edge_sel_q & s_q);
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    if (wr_en && address == REG_MASK)     mask_d     = wr_byte;
    if (wr_en && address == REG_EDGE_SEL) edge_sel_d = wr_byte;
  end

  // Lowest-numbered masked pending source wins.
  always_comb begin
    act_valid = 1'b0;
    act_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (masked[i]) begin
        act_valid = 1'b1;
        act_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    readdata_d = 16'h0000;
    case (address)
      REG_PENDING:  readdata_d = {8'h00, pending_q};
      REG_MASK:     readdata_d = {8'h00, mask_q};
      REG_EDGE_SEL: readdata_d = {8'h00, edge_sel_q};
      REG_ACTIVE:   readdata_d = {act_valid, 12'h000, act_idx};
      default:      readdata_d = 16'h0000;
    endcase
  end

  assign irq_d = |masked;

  // NOTE: all state here is small flops, so every register takes the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q        <= '0;
      p_q        <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s_q        <= s_d;
      p_q        <= s_q;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_q;

endmodule

// File: doc/irq_aggregator.md
IRQ_AGGREGATOR -- requirements
Module: irq_aggregator

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state SHALL be updated on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have port address, input, 3, Avalon-MM slave word address.
REQ-004 SHALL have port chipselect, input, 1, slave select.
REQ-005 SHALL have port write_n, input, 1, active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-006 SHALL have port writedata, input, 16, write data; only bits [7:0] are used.
REQ-007 SHALL have port readdata, output, 16, registered read data.
REQ-008 SHALL have port irq_in, input, 8, interrupt sources; bit 0 is the system clock timer irq.
REQ-009 SHALL have port irq_out, output, 1, registered aggregated interrupt to the CPU.

Function
REQ-010 SHALL implement this register map: 0 PENDING (read; write-1-to-clear), 1 MASK (read/write), 2 EDGE_SEL (read/write; 1=edge, 0=level), 3 ACTIVE (read-only), 4 FORCE (write-only; reads 0); addresses 5-7 read 0 and ignore writes.
REQ-011 SHALL register irq_in into sample register s every cycle, then register s into prev register p.
REQ-012 For an edge source i, pending[i] SHALL set on the edge after s[i]=1 and p[i]=0, or on a FORCE write with writedata[i]=1.
REQ-013 For an edge source i, pending[i] SHALL clear on a PENDING write with writedata[i]=1; if set and clear coincide, set SHALL win.
REQ-014 For a level source i, pending[i] SHALL load s[i] every cycle; W1C and FORCE writes SHALL have no effect on it.
REQ-015 Changing EDGE_SEL[i] from 0 to 1 SHALL retain the current pending[i] value; changing it from 1 to 0 SHALL resume level tracking on the next cycle.
REQ-016 irq_out SHALL be registered as |(pending & MASK), so it lags pending by one cycle.
REQ-017 Without synchronizer, irq_out SHALL assert exactly 2 cycles after the clock edge at which irq_in is first sampled high.
REQ-018 ACTIVE SHALL read {valid, 12'b0, idx[2:0]}, with valid in bit 15 and idx in bits [2:0], where idx is the lowest-numbered set bit of pending & MASK; when none is set, valid=0 and idx=0.
REQ-019 readdata SHALL be registered from the current address every cycle, with 1-cycle read latency, regardless of chipselect.
REQ-020 readdata bits [15:8] SHALL read 0 for PENDING, MASK and EDGE_SEL.
REQ-021 Register writes SHALL take effect on the clock edge of the write cycle; a read of the same register on the next cycle SHALL return the new value.

Reset
REQ-022 On reset_n=0, the following SHALL be cleared asynchronously: s, p, synchronizer flops, pending, MASK, EDGE_SEL, readdata, and irq_out.
REQ-023 Reset asserted mid-operation SHALL discard pending events; no interrupt SHALL be generated on reset release unless a source is high (level mode) or rises after release.

Configuration
REQ-024 When macro IRQ_AGGREGATOR_SYNC_EN is defined, irq_in SHALL pass through a two-flop synchronizer before s, and irq_out latency per REQ-017 SHALL become 4 cycles.
REQ-025 Without IRQ_AGGREGATOR_SYNC_EN, irq_in SHALL feed s directly, and the register map and all other behaviour SHALL be identical in both builds.

Verification
REQ-026 Set MASK=0x01 and EDGE_SEL=0x00, drive irq_in[0]=1 -> irq_out=1 after 2 cycles (4 with sync); drive irq_in[0]=0 -> irq_out=0 after 2 cycles; ACTIVE reads 0x8000 while asserted.
REQ-027 Set EDGE_SEL=0xFF and MASK=0xFF, pulse irq_in[3] for 1 cycle -> PENDING=0x08 and ACTIVE=0x8003; write PENDING=0x08 -> PENDING=0x00 and irq_out=0 one cycle later.
REQ-028 In edge mode, write PENDING W1C of bit 2 in the same cycle a new rising edge of irq_in[2] is detected -> PENDING bit 2 remains 1.
REQ-029 Set MASK=0x00 and write FORCE=0x30 with EDGE_SEL=0x30 -> PENDING=0x30 and irq_out=0; then write MASK=0x20 -> irq_out=1 and ACTIVE=0x8005.
REQ-030 Hold irq_in=0xFF in level mode with MASK=0xFF, assert reset_n=0 mid-stream -> all outputs 0 immediately; after release, pending=0xFF after 2 cycles and irq_out=1 after 3 cycles; reads of address 6 return 0x0000.
